// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Size codes, FSM states and the default bus timeout.
package lsu_pkg;

  localparam int LSU_TIMEOUT = 255;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      size == SZ_B: ok = 1'b1;
      size == SZ_H: ok = ~off[0];
      size == SZ_W: ok = (off == 2'b00);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Lane formatting: store byte enables and replication,
// load lane select with sign or zero extension.
module lsu_fmt
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    st_size,
  input  logic [1:0]    st_off,
  input  logic [DW-1:0] st_wdata,
  output logic [3:0]    st_be,
  output logic [DW-1:0] st_data,
  input  logic [1:0]    ld_size,
  input  logic [1:0]    ld_off,
  input  logic          ld_uns,
  input  logic [DW-1:0] ld_rdata,
  output logic [DW-1:0] ld_data
);

  logic [DW-1:0] b_lane;
  logic [DW-1:0] h_lane;
  logic [7:0]    b;
  logic [15:0]   h;

  // Store side: enables from size/offset, data copied to every lane.
  always_comb begin
    st_be   = 4'b1111;
    st_data = st_wdata;
    unique case (1'b1)
      st_size == SZ_B: begin
        st_be   = 4'b0001 << st_off;
        st_data = {(DW/8){st_wdata[7:0]}};
      end
      st_size == SZ_H: begin
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
        st_data = {(DW/16){st_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = st_wdata;
      end
    endcase
  end

  // Load side: shift the addressed lane down, then extend.
  always_comb begin
    b_lane  = ld_rdata >> {ld_off, 3'b000};
    h_lane  = ld_rdata >> {ld_off[1], 4'b0000};
    b       = b_lane[7:0];
    h       = h_lane[15:0];
    ld_data = ld_rdata;
    unique case (1'b1)
      ld_size == SZ_B:
        ld_data = {{(DW-8){b[7] & ~ld_uns}}, b};
      ld_size == SZ_H:
        ld_data = {{(DW-16){h[15] & ~ld_uns}}, h};
      default:
        ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding bus access per request,
// with alignment checks, lane formatting and bus timeout.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WITDH = 32,
  parameter int ADDR_WITDH = 32,
  parameter int TIMEOUT    = LSU_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WITDH-1:0] req_addr,
  input  logic [DATA_WITDH-1:0] req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WITDH-1:0] data_out,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WITDH-1:0] bus_addr,
  output logic [DATA_WITDH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ack,
  input  logic [DATA_WITDH-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                state, state_n;
  logic [CW-1:0]         cnt;
  logic                  r_we;
  logic                  r_uns;
  logic [1:0]            r_size;
  logic [1:0]            r_off;
  logic [ADDR_WITDH-1:0] r_addr;
  logic [DATA_WITDH-1:0] r_wdata;
  logic [3:0]            r_be;

  logic                  in_req, ok, acc, bad, tmo;
  logic [3:0]            st_be;
  logic [DATA_WITDH-1:0] st_data;
  logic [DATA_WITDH-1:0] ld_data;

  assign in_req = (state == REQ);
  assign ok     = is_aligned(req_size, req_addr[1:0]);
  assign acc    = !in_req && req_valid && ok;
  assign bad    = !in_req && req_valid && !ok;
  assign tmo    = in_req && !bus_ack &&
                  (cnt == CW'(TIMEOUT - 1));

  lsu_fmt #(.DW(DATA_WITDH)) u_fmt (
    .st_size  (req_size),
    .st_off   (req_addr[1:0]),
    .st_wdata (req_wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .ld_size  (r_size),
    .ld_off   (r_off),
    .ld_uns   (r_uns),
    .ld_rdata (bus_rdata),
    .ld_data  (ld_data)
  );

  assign stall     = rst & (in_req | acc);
  assign done      = (state == DONE);
  assign bus_req   = in_req;
  assign bus_we    = in_req & r_we;
  assign bus_addr  = in_req ? r_addr  : '0;
  assign bus_wdata = in_req ? r_wdata : '0;
  assign bus_be    = in_req ? r_be    : '0;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state: ack beats timeout in the same cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: state_n = acc ? REQ : IDLE;
      REQ: begin
        if (bus_ack)  state_n = DONE;
        else if (tmo) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture, wait counter, result and pulse flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_size   <= 2'b00;
      r_off    <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      data_out <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      misalign <= bad;
      bus_err  <= tmo;
      if (acc) begin
        cnt     <= '0;
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_size  <= req_size;
        r_off   <= req_addr[1:0];
        r_addr  <= {req_addr[ADDR_WITDH-1:2], 2'b00};
        r_wdata <= st_data;
        r_be    <= st_be;
      end else if (in_req && !bus_ack) begin
        cnt <= tmo ? '0 : cnt + CW'(1);
      end
      if (in_req && bus_ack && !r_we) data_out <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a load-result scoreboard.
// Outputs are sampled 1ns after the rising edge.
module tb_mem_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misalign, bus_err;
  logic [31:0] data_out;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_ld;

  always #5 clk = ~clk;

  mem_lsu #(
    .DATA_WITDH (32),
    .ADDR_WITDH (32),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .done         (done),
    .data_out     (data_out),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic        we,
                        input logic [1:0]  size,
                        input logic        uns,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [31:0] rdata,
                        input int          dly,
                        input logic [3:0]  ebe,
                        input logic [31:0] ewd,
                        input logic [31:0] eld);
    logic [31:0] exp;
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    #1;
    chk("accept_stall", stall, 1);
    if (!we) last_ld = eld;
    sb.push_back(last_ld);
    tick();
    req_valid = 1'b0;
    #1;
    for (int i = 0; i <= dly; i++) begin
      chk("req_bus_req", bus_req, 1);
      chk("req_stall", stall, 1);
      chk("req_bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
      chk("req_bus_we", bus_we, we);
      if (we) begin
        chk("req_bus_be", bus_be, ebe);
        chk("req_bus_wdata", bus_wdata, ewd);
      end
      if (i == dly) begin
        bus_ack = 1'b1;
        bus_rdata = rdata;
      end
      tick();
      bus_ack = 1'b0;
      bus_rdata = 32'h5A5A_5A5A;
    end
    chk("done_pulse", done, 1);
    chk("done_bus_req", bus_req, 0);
    chk("done_bus_err", bus_err, 0);
    chk("done_stall", stall, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      exp = sb.pop_front();
      chk("data_out", data_out, exp);
    end
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  task automatic bad_op(input logic [1:0] size,
                        input logic [31:0] addr);
    req_valid = 1'b1; req_we = 1'b0; req_size = size;
    req_unsigned = 1'b0; req_addr = addr;
    #1;
    chk("bad_stall", stall, 0);
    tick();
    req_valid = 1'b0;
    #1;
    chk("bad_misalign", misalign, 1);
    chk("bad_bus_req", bus_req, 0);
    tick();
    chk("bad_misalign_clr", misalign, 0);
    chk("bad_bus_req2", bus_req, 0);
    chk("bad_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    last_ld = 32'h0;
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_be", bus_be, 0);
    req_valid = 1'b0;
    rst = 1'b1;
    tick();

    run_op(0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0,
           4'h0, 0, 32'hDEADBEEF);
    run_op(0, 2'b00, 0, 32'h103, 0, 32'h8000_0000, 0,
           4'h0, 0, 32'hFFFF_FF80);
    run_op(0, 2'b00, 1, 32'h103, 0, 32'h8000_0000, 0,
           4'h0, 0, 32'h0000_0080);
    run_op(1, 2'b01, 0, 32'h202, 32'h1234, 0, 0,
           4'b1100, 32'h1234_1234, 0);
    run_op(1, 2'b00, 0, 32'h101, 32'hFFAB, 0, 1,
           4'b0010, 32'hABAB_ABAB, 0);
    run_op(1, 2'b01, 0, 32'h204, 32'h5678_9ABC, 0, 0,
           4'b0011, 32'h9ABC_9ABC, 0);
    run_op(1, 2'b10, 0, 32'h208, 32'hCAFE_F00D, 0, 0,
           4'b1111, 32'hCAFE_F00D, 0);
    run_op(0, 2'b01, 0, 32'h102, 0, 32'h8001_1234, 0,
           4'h0, 0, 32'hFFFF_8001);
    run_op(0, 2'b01, 1, 32'h100, 0, 32'h8001_F234, 2,
           4'h0, 0, 32'h0000_F234);
    run_op(0, 2'b00, 0, 32'h101, 0, 32'h0000_7F00, 3,
           4'h0, 0, 32'h0000_007F);
    run_op(0, 2'b10, 0, 32'h110, 0, 32'h1357_9BDF, TO - 1,
           4'h0, 0, 32'h1357_9BDF);

    bad_op(2'b10, 32'h101);
    bad_op(2'b01, 32'h103);
    bad_op(2'b11, 32'h100);

    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h300;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (bus_req && n < 100) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", n, TO);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_done", done, 0);
    chk("tmo_data_out", data_out, last_ld);
    tick();
    chk("tmo_bus_err_clr", bus_err, 0);
    chk("tmo_idle", bus_req, 0);

    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_addr = 32'h400;
    tick();
    req_valid = 1'b0;
    #1;
    chk("mid_bus_req", bus_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bus_req", bus_req, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_bus_addr", bus_addr, 0);
    tick();
    rst = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'h0BAD_0BAD;
    tick();
    bus_ack = 1'b0;
    chk("late_ack_done", done, 0);
    chk("late_ack_bus_req", bus_req, 0);
    tick();
    chk("late_ack_done2", done, 0);
    chk("late_ack_data_out", data_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
